otter_cu_fsm: RTL and testbench

Multi-cycle control-unit state machine for the OTTER RV32I CPU. It sequences fetch, execute and writeback by driving the PC register's write enable and synchronous reset, the register-file write enable, and the memory read/write strobes. It sits beside the combinational decoder that selects PC source and ALU function. It owns all timing: which cycle an instruction commits and when the PC advances.

---
 rtl/otter_pkg.sv | 26 ++
 rtl/otter_cu_fsm.sv | 125 ++++++++++++
 tb/tb_otter_cu_fsm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I major opcodes and control-unit states.
// Used by the control-unit FSM, the decoder and the ALU.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multi-cycle OTTER control unit: sequences fetch/exec/writeback and interrupt entry.
// Interrupt entry and CSR writes are built only when OTTER_INTR_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] OPCODE,
  input  logic       INTR,
  output logic       PC_RST,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       ILLEGAL,
  output logic       INT_TAKEN,
  output logic       CSR_WE,
  output cu_state_t  STATE_DBG
);

  localparam logic [3:0] WB_WAIT = 4'(MEM_LAT - 1);

  cu_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       intr_take;

`ifdef OTTER_INTR_EN
  assign intr_take = INTR;
`else
  logic unused_intr;
  assign unused_intr = INTR;
  assign intr_take   = 1'b0;
`endif

  // Outputs are a pure function of state and OPCODE, so an asynchronous
  // reset drops any in-flight strobe (e.g. MEM_WE2) in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    PC_RST    = 1'b0;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    ILLEGAL   = 1'b0;
    INT_TAKEN = 1'b0;
    CSR_WE    = 1'b0;
    case (state_q)
      ST_INIT: begin
        PC_RST  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        case (OPCODE)
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
          end
          OPC_BRANCH: PC_WRITE = 1'b1;
          OPC_STORE: begin
            PC_WRITE = 1'b1;
            MEM_WE2  = 1'b1;
          end
          OPC_SYSTEM: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
`ifdef OTTER_INTR_EN
            CSR_WE    = 1'b1;
`endif
          end
          OPC_LOAD: begin
            MEM_RDEN2 = 1'b1;
            cnt_d     = WB_WAIT;
            state_d   = ST_WB;
          end
          default: begin
            PC_WRITE = 1'b1;
            ILLEGAL  = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          PC_WRITE  = 1'b1;
          REG_WRITE = 1'b1;
        end
      end
      ST_INTR: begin
`ifdef OTTER_INTR_EN
        PC_WRITE  = 1'b1;
        INT_TAKEN = 1'b1;
`endif
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
    // A PC write in EXEC or WB is the commit cycle; the only point INTR is sampled.
    if (PC_WRITE && (state_q == ST_EXEC || state_q == ST_WB)) begin
      state_d = intr_take ? ST_INTR : ST_FETCH;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed self-checking bench for otter_cu_fsm (MEM_LAT=3), default or OTTER_INTR_EN build.
module tb_otter_cu_fsm;
  import otter_pkg::*;

  localparam int unsigned LAT = 3;

  // Output vector order: PC_RST PC_WRITE REG_WRITE RDEN1 RDEN2 WE2 ILLEGAL INT_TAKEN CSR_WE
  localparam logic [8:0] V_INIT  = 9'b100000000;
  localparam logic [8:0] V_FETCH = 9'b000100000;
  localparam logic [8:0] V_ALU   = 9'b011000000;
  localparam logic [8:0] V_BR    = 9'b010000000;
  localparam logic [8:0] V_ST    = 9'b010001000;
  localparam logic [8:0] V_LD    = 9'b000010000;
  localparam logic [8:0] V_IDLE  = 9'b000000000;
  localparam logic [8:0] V_ILL   = 9'b010000100;
  localparam logic [8:0] V_INT   = 9'b010000010;
`ifdef OTTER_INTR_EN
  localparam logic [8:0] V_SYS   = 9'b011000001;
`else
  localparam logic [8:0] V_SYS   = 9'b011000000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       intr = 1'b0;
  logic       pc_rst, pc_write, reg_write, rden1, rden2, we2, illegal, int_taken, csr_we;
  cu_state_t  state_dbg;
  logic [8:0] out_vec;

  logic [8:0] exp_q[$];
  cu_state_t  exp_st_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  otter_cu_fsm #(.MEM_LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n), .OPCODE(opcode), .INTR(intr),
    .PC_RST(pc_rst), .PC_WRITE(pc_write), .REG_WRITE(reg_write),
    .MEM_RDEN1(rden1), .MEM_RDEN2(rden2), .MEM_WE2(we2),
    .ILLEGAL(illegal), .INT_TAKEN(int_taken), .CSR_WE(csr_we),
    .STATE_DBG(state_dbg)
  );

  assign out_vec = {pc_rst, pc_write, reg_write, rden1, rden2, we2, illegal, int_taken, csr_we};

  task automatic push_exp(input logic [8:0] e, input cu_state_t st);
    exp_q.push_back(e);
    exp_st_q.push_back(st);
  endtask

  task automatic check(input string tag);
    logic [8:0] e;
    cu_state_t  st;
    e  = exp_q.pop_front();
    st = exp_st_q.pop_front();
    n_cmp++;
    assert (out_vec === e) else begin
      n_err++;
      $error("FAIL %s outputs: observed %b expected %b", tag, out_vec, e);
    end
    n_cmp++;
    assert (state_dbg === st) else begin
      n_err++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, st);
    end
  endtask

  // Drive inputs just after a rising edge, compare on the following falling edge.
  task automatic step(input string tag, input logic [6:0] opc, input logic irq,
                      input logic [8:0] e, input cu_state_t st);
    @(posedge clk);
    #1;
    opcode = opc;
    intr   = irq;
    push_exp(e, st);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    push_exp(V_INIT, ST_INIT);
    check("in_reset");
    #1 rst_n = 1'b1;
    push_exp(V_INIT, ST_INIT);
    check("init_after_release");

    // OP
    step("op_fetch", 7'b0110011, 1'b0, V_FETCH, ST_FETCH);
    step("op_exec",  7'b0110011, 1'b0, V_ALU,   ST_EXEC);
    // LOAD with MEM_LAT=3: two idle WB cycles then commit
    step("ld_fetch", 7'b0000011, 1'b0, V_FETCH, ST_FETCH);
    step("ld_exec",  7'b0000011, 1'b0, V_LD,    ST_EXEC);
    step("ld_wb2",   7'b0000011, 1'b0, V_IDLE,  ST_WB);
    step("ld_wb1",   7'b0000011, 1'b0, V_IDLE,  ST_WB);
    step("ld_commit",7'b0000011, 1'b0, V_ALU,   ST_WB);
    // STORE, BRANCH, illegal, LUI, SYSTEM
    step("st_fetch", 7'b0100011, 1'b0, V_FETCH, ST_FETCH);
    step("st_exec",  7'b0100011, 1'b0, V_ST,    ST_EXEC);
    step("br_fetch", 7'b1100011, 1'b0, V_FETCH, ST_FETCH);
    step("br_exec",  7'b1100011, 1'b0, V_BR,    ST_EXEC);
    step("ill_fetch",7'b1111111, 1'b0, V_FETCH, ST_FETCH);
    step("ill_exec", 7'b1111111, 1'b0, V_ILL,   ST_EXEC);
    step("lui_fetch",7'b0110111, 1'b0, V_FETCH, ST_FETCH);
    step("lui_exec", 7'b0110111, 1'b0, V_ALU,   ST_EXEC);
    step("sys_fetch",7'b1110011, 1'b0, V_FETCH, ST_FETCH);
    step("sys_exec", 7'b1110011, 1'b0, V_SYS,   ST_EXEC);

    // INTR on the OP commit cycle
    step("irq_fetch",7'b0110011, 1'b0, V_FETCH, ST_FETCH);
    step("irq_exec", 7'b0110011, 1'b1, V_ALU,   ST_EXEC);
`ifdef OTTER_INTR_EN
    step("irq_entry",7'b0110011, 1'b0, V_INT,   ST_INTR);
`endif
    // INTR only during FETCH is lost
    step("irq_late_fetch", 7'b0110011, 1'b1, V_FETCH, ST_FETCH);
    step("irq_late_exec",  7'b0110011, 1'b0, V_ALU,   ST_EXEC);
    step("irq_none",       7'b0010011, 1'b0, V_FETCH, ST_FETCH);
    step("opimm_exec",     7'b0010011, 1'b0, V_ALU,   ST_EXEC);

    // Reset during a STORE exec cycle drops MEM_WE2 immediately
    step("rst_st_fetch", 7'b0100011, 1'b0, V_FETCH, ST_FETCH);
    step("rst_st_exec",  7'b0100011, 1'b0, V_ST,    ST_EXEC);
    #2 rst_n = 1'b0;
    #1;
    push_exp(V_INIT, ST_INIT);
    check("rst_mid_store");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_exp(V_INIT, ST_INIT);
    check("rst2_init");
    step("rst2_fetch", 7'b0000011, 1'b0, V_FETCH, ST_FETCH);
    step("rst2_ld",    7'b0000011, 1'b0, V_LD,    ST_EXEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
